fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage plus IF/ID pipeline register of the 5-stage RV32I core. Owns the PC and fetches from
//  the instruction memory. Latches {pc, inst, valid} into IF/ID and drives the IF_ID rs1/rs2 fields.
//  Those fields feed the load-use hazard unit, whose stall output returns here to freeze PC and IF/ID.
//  Branch/jump redirect from EX flushes IF/ID; also keeps saturating stall/flush perf counters.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset (bits [1:0] must be 0)
//  NOP_INST  32'h0000_0013  bubble instruction (addi x0,x0,0) written into IF/ID on reset/flush
//  CNT_W     32             width of stall_count / flush_count
// PORTS
//  clk                 in   1      rising-edge clock
//  rst                 in   1      asynchronous, active-high reset
//  stall               in   1      load-use stall from hazard unit: hold PC and IF/ID
//  flush               in   1      branch/jump taken in EX: redirect PC, bubble IF/ID
//  branch_target       in   32     redirect address, valid when flush=1
//  imem_addr           out  32     instruction memory address (= pc), combinational read
//  imem_rdata          in   32     instruction word at imem_addr, same cycle
//  pc                  out  32     current fetch PC
//  IF_ID_pc            out  32     PC of instruction held in IF/ID
//  IF_ID_inst          out  32     instruction held in IF/ID
//  IF_ID_valid         out  1      1 = IF/ID holds a real instruction, 0 = bubble
//  IF_ID_RegisterRs1   out  5      IF_ID_inst[19:15], combinational from register
//  IF_ID_RegisterRs2   out  5      IF_ID_inst[24:20], combinational from register
//  stall_count         out  CNT_W  cycles with stall=1 and flush=0, saturating
//  flush_count         out  CNT_W  cycles with flush=1, saturating
// BEHAVIOUR
//  - Reset (async, immediate on rst rise, held while rst=1): pc=RESET_PC, IF_ID_pc=0,
//    IF_ID_inst=NOP_INST, IF_ID_valid=0, stall_count=0, flush_count=0.
//  - imem_addr = pc at all times; no wait states; instruction fetch latency = 1 cycle to IF/ID.
//  - Per-edge priority when rst=0: flush > stall > normal advance.
//    flush=1 (stall ignored): pc<=branch_target&~32'h3; IF_ID_inst<=NOP_INST, IF_ID_valid<=0,
//      IF_ID_pc<=pc; flush_count+=1.
//    stall=1, flush=0: pc, IF_ID_* unchanged; imem_rdata discarded; stall_count+=1.
//    else: pc<=pc+4 (32-bit wrap, FFFF_FFFC -> 0000_0000); IF_ID_pc<=pc,
//      IF_ID_inst<=imem_rdata, IF_ID_valid<=1.
//  - Stall for N consecutive cycles holds IF/ID for N cycles; first advance after release
//    latches imem_rdata at the held pc (no instruction lost or duplicated).
//  - Flush during multi-cycle stall: flush wins that cycle; stall next cycle holds the bubble
//    and the new pc.
//  - Counters saturate at all-ones and never wrap; both only increment when rst=0.
//  - Rs1/Rs2 fields are always decoded, even for bubbles (NOP gives rs1=0, rs2=0).
//    A bubble therefore never causes a hazard-unit stall.
//  - rst asserted mid-stall or mid-flush: reset state wins immediately; first post-reset fetch at RESET_PC.
// STRUCTURE
//  - Shared package (core pkg): NOP_INST constant, XLEN=32, RS1/RS2 field bit positions.
//  - One sub-module: if_id_reg (async-reset register with hold/flush inputs carrying
//    pc/inst/valid). PC register, next-PC logic and counters stay in fetch_stage.
// TESTING
//  1 Reset: assert rst with imem_rdata=32'hDEAD_BEEF -> pc=0, IF_ID_inst=0000_0013, valid=0, counts=0.
//  2 Sequential fetch: imem returns 00500093 at 0, 00A00113 at 4 -> after 2 edges
//    IF_ID_pc=4, IF_ID_inst=00A00113, Rs1=0, pc=8.
//  3 Stall: stall=1 for 3 cycles at pc=8 -> pc stays 8, IF/ID unchanged, stall_count=3;
//    release -> IF_ID_pc=8.
//  4 Flush: flush=1, branch_target=32'h0000_0042 -> pc=0000_0040, IF_ID_valid=0,
//    IF_ID_inst=0000_0013, flush_count=1.
//  5 Simultaneous stall=1, flush=1 -> flush behaviour only; stall_count unchanged.
//  6 Wrap/saturate: pc=FFFF_FFFC advances to 0; force stall_count=all-ones, stall -> stays all-ones.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared core definitions for the fetch stage: data width, the bubble
// instruction, and the rs1/rs2 field positions inside an RV32I instruction.
// Holds no logic. It is imported by fetch_stage and if_id_reg.
package fetch_stage_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned RS1_LSB  = 15;
  localparam int unsigned RS2_LSB  = 20;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  // Extract a 5-bit register specifier starting at bit lsb.
  function automatic logic [REG_W-1:0] reg_field(input logic [XLEN-1:0] inst,
                                                 input int unsigned     lsb);
    return inst[lsb +: REG_W];
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register carrying {pc, inst, valid}.
// Ports: clk/rst (async active-high); hold_i keeps the contents; flush_i loads a
// bubble (NOP, valid=0) but still records pc_i; pc_i/inst_i feed the register, and *_o return its contents.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] inst_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic            valid_q, valid_d;

  // flush takes priority over hold
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (flush_i) begin
      pc_d    = pc_i;
      inst_d  = NOP;
      valid_d = 1'b0;
    end else if (!hold_i) begin
      pc_d    = pc_i;
      inst_d  = inst_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      inst_q  <= NOP;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage and IF/ID register of the RV32I core. It owns the PC and reads imem combinationally.
// Ports: clk, rst (async active-high); stall/flush/branch_target come from the hazard unit and EX; imem_addr/imem_rdata form the fetch port;
// pc, IF_ID_* hold the pipeline state, IF_ID_RegisterRs1/Rs2 go to the hazard unit, and stall_count/flush_count are saturating counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = fetch_stage_pkg::NOP_INST,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      branch_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      IF_ID_pc,
  output logic [31:0]      IF_ID_inst,
  output logic             IF_ID_valid,
  output logic [4:0]       IF_ID_RegisterRs1,
  output logic [4:0]       IF_ID_RegisterRs2,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_eff;

  // A redirect overrides a simultaneous load-use stall.
  assign stall_eff = stall & ~flush;

  always_comb begin
    pc_d        = pc_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      pc_d = branch_target & ~32'h3;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
    end else if (stall) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  if_id_reg #(.NOP(NOP_INST)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .hold_i  (stall_eff),
    .flush_i (flush),
    .pc_i    (pc_q),
    .inst_i  (imem_rdata),
    .pc_o    (IF_ID_pc),
    .inst_o  (IF_ID_inst),
    .valid_o (IF_ID_valid)
  );

  // Decoded even for bubbles. The NOP yields x0/x0, so a bubble can never trigger a stall.
  assign IF_ID_RegisterRs1 = reg_field(IF_ID_inst, RS1_LSB);
  assign IF_ID_RegisterRs2 = reg_field(IF_ID_inst, RS2_LSB);

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage. It runs directed steps and then a random stall/flush mix.
// The results are checked against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall, flush;
  logic [31:0]      branch_target;
  logic [31:0]      imem_addr, imem_rdata;
  logic [31:0]      pc, IF_ID_pc, IF_ID_inst;
  logic             IF_ID_valid;
  logic [4:0]       IF_ID_RegisterRs1, IF_ID_RegisterRs2;
  logic [CNT_W-1:0] stall_count, flush_count;

  logic [31:0] mem [0:63];
  logic        mem_override;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0] m_pc, m_ifpc, m_inst;
  logic        m_valid;
  int          m_sc, m_fc;

  always #5 clk = ~clk;

  assign imem_rdata = mem_override ? 32'hDEAD_BEEF : mem[imem_addr[7:2]];

  fetch_stage #(.RESET_PC(32'h0), .NOP_INST(NOP), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .branch_target     (branch_target),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .pc                (pc),
    .IF_ID_pc          (IF_ID_pc),
    .IF_ID_inst        (IF_ID_inst),
    .IF_ID_valid       (IF_ID_valid),
    .IF_ID_RegisterRs1 (IF_ID_RegisterRs1),
    .IF_ID_RegisterRs2 (IF_ID_RegisterRs2),
    .stall_count       (stall_count),
    .flush_count       (flush_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_inst = NOP; m_valid = 1'b0; m_sc = 0; m_fc = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    pc,                   m_pc);
    check({tag, ".addr"},  imem_addr,            m_pc);
    check({tag, ".ifpc"},  IF_ID_pc,             m_ifpc);
    check({tag, ".inst"},  IF_ID_inst,           m_inst);
    check({tag, ".valid"}, {31'b0, IF_ID_valid}, {31'b0, m_valid});
    check({tag, ".rs1"},   {27'b0, IF_ID_RegisterRs1}, {27'b0, m_inst[19:15]});
    check({tag, ".rs2"},   {27'b0, IF_ID_RegisterRs2}, {27'b0, m_inst[24:20]});
    check({tag, ".scnt"},  {28'b0, stall_count}, m_sc);
    check({tag, ".fcnt"},  {28'b0, flush_count}, m_fc);
  endtask

  // Drive one cycle's inputs, let an edge pass, advance the model, check #1 later.
  task automatic step(input string tag, input logic s, input logic f, input logic [31:0] tgt);
    logic [31:0] fetched;
    stall = s; flush = f; branch_target = tgt;
    fetched = mem[m_pc[7:2]];
    @(posedge clk);
    if (f) begin
      m_ifpc = m_pc; m_pc = {tgt[31:2], 2'b00}; m_inst = NOP; m_valid = 1'b0;
      m_fc = (m_fc < CNT_MAX) ? m_fc + 1 : CNT_MAX;
    end else if (s) begin
      m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : CNT_MAX;
    end else begin
      m_ifpc = m_pc; m_inst = fetched; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = '0; mem_override = 1'b1;
    model_reset();

    // 1: reset state with garbage on the fetch port
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk);
    rst = 1'b0; mem_override = 1'b0;

    // 2: sequential fetch
    step("seq0", 1'b0, 1'b0, 32'h0);
    step("seq1", 1'b0, 1'b0, 32'h0);
    check("seq.ifinst", IF_ID_inst, 32'h00A0_0113);
    check("seq.pc8", pc, 32'h8);

    // 3: three stall cycles, then release
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 32'h0);
    check("stall.cnt3", {28'b0, stall_count}, 32'd3);
    step("release", 1'b0, 1'b0, 32'h0);
    check("release.ifpc", IF_ID_pc, 32'h8);

    // 4: flush with an unaligned target
    step("flush", 1'b0, 1'b1, 32'h0000_0042);
    check("flush.pc", pc, 32'h0000_0040);

    // 5: stall and flush together; stall then holds the bubble
    step("both", 1'b1, 1'b1, 32'h0000_0100);
    step("both.hold", 1'b1, 1'b0, 32'h0);
    step("both.go", 1'b0, 1'b0, 32'h0);

    // 6: PC wrap and counter saturation
    step("wrapf", 1'b0, 1'b1, 32'hFFFF_FFFF);
    step("wrap", 1'b0, 1'b0, 32'h0);
    check("wrap.pc0", pc, 32'h0);
    for (int i = 0; i < 20; i++) step("sat", 1'b1, 1'b0, 32'h0);
    check("sat.scnt", {28'b0, stall_count}, CNT_MAX);
    for (int i = 0; i < 16; i++) step("fsat", 1'b0, 1'b1, $urandom);

    // reset mid-stall wins immediately
    step("pre", 1'b1, 1'b0, 32'h0);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("midrst");
    @(negedge clk);
    rst = 1'b0;
    step("postrst", 1'b0, 1'b0, 32'h0);

    // random mix
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 9);
      step("rand", r < 3, r >= 8, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
